// File: rtl/nv_nvdla_sdp_core_c_core_io_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// nv_nvdla_sdp_core_c_core_io_ctrl_pkg
// Shared SDP C-core definitions: default data width, pipeline latency and
// result FIFO depth, the count/pointer widths derived from them, and the
// FIFO operation encoding used by the result buffer.
// ----------------------------------------------------------------------------
package nv_nvdla_sdp_core_c_core_io_ctrl_pkg;

   localparam int unsigned DEF_DW    = 32;
   localparam int unsigned DEF_LAT   = 3;
   localparam int unsigned DEF_DEPTH = 2;

   // Occupancy counter must represent 0..DEPTH inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers index 0..DEPTH-1; a one-entry FIFO still needs a 1-bit pointer.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned DEF_CNT_W = cnt_width(DEF_DEPTH);
   localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);

   // {push, pop} as seen by the result FIFO in one cycle.
   typedef enum logic [1:0] {
      FIFO_OP_IDLE = 2'b00,
      FIFO_OP_POP  = 2'b01,
      FIFO_OP_PUSH = 2'b10,
      FIFO_OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/nv_nvdla_sdp_core_c_core_io_ctrl_if.sv
// ----------------------------------------------------------------------------
// nv_nvdla_sdp_core_c_core_io_ctrl_if
// Channel bundle around the C-core handshake/stall controller.
//   chn_in_vld / chn_in_rdy     : input operand channel
//   core_wen                    : core advance enable
//   core_res_data [DW]          : core last-stage result
//   chn_out_vld / chn_out_rdy   : output result channel
//   chn_out_data [DW]           : output result head
//   core_idle                   : nothing in flight or buffered
// Modports: slave = the controller, master = its surroundings.
// ----------------------------------------------------------------------------
interface nv_nvdla_sdp_core_c_core_io_ctrl_if
   import nv_nvdla_sdp_core_c_core_io_ctrl_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
);

   logic          chn_in_vld;
   logic          chn_in_rdy;
   logic          core_wen;
   logic [DW-1:0] core_res_data;
   logic          chn_out_vld;
   logic          chn_out_rdy;
   logic [DW-1:0] chn_out_data;
   logic          core_idle;

   modport master (
      output chn_in_vld,
      input  chn_in_rdy,
      input  core_wen,
      output core_res_data,
      input  chn_out_vld,
      output chn_out_rdy,
      input  chn_out_data,
      input  core_idle
   );

   modport slave (
      input  chn_in_vld,
      output chn_in_rdy,
      output core_wen,
      input  core_res_data,
      output chn_out_vld,
      input  chn_out_rdy,
      output chn_out_data,
      output core_idle
   );

endinterface

// File: rtl/nv_nvdla_sdp_core_c_res_fifo.sv
// ----------------------------------------------------------------------------
// nv_nvdla_sdp_core_c_res_fifo
// Synchronous DEPTH x DW result FIFO. No same-cycle bypass: a push into an
// empty FIFO is visible at pop_data on the following cycle.
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write tail (ignored when full unless popping)
//   pop                : retire head (ignored when empty)
//   pop_data           : head entry
//   cnt, full, empty   : occupancy status
// Storage is not reset; only pointers and count are.
// ----------------------------------------------------------------------------
module nv_nvdla_sdp_core_c_res_fifo
   import nv_nvdla_sdp_core_c_core_io_ctrl_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned PTR_W = DEF_PTR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [DW-1:0]    push_data,
   input  logic             pop,
   output logic [DW-1:0]    pop_data,
   output logic [CNT_W-1:0] cnt,
   output logic             full,
   output logic             empty
);

   logic [DW-1:0]    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   fifo_op_e         op;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      empty   = (cnt == '0);
      full    = (cnt == CNT_W'(DEPTH));
      do_pop  = pop & ~empty;
      // A push into a full FIFO is only legal when the head leaves this cycle.
      do_push = push & (~full | do_pop);
      op      = fifo_op_e'({do_push, do_pop});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case (op)
            FIFO_OP_PUSH: cnt <= cnt + 1'b1;
            FIFO_OP_POP:  cnt <= cnt - 1'b1;
            default:      cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/nv_nvdla_sdp_core_c_core_io_ctrl.sv
// ----------------------------------------------------------------------------
// nv_nvdla_sdp_core_c_core_io_ctrl
// Handshake and stall controller for the SDP C-core pipeline. Turns the
// input and output valid/ready channels into a single advance enable
// (core_wen), tracks which pipeline stages hold valid operands, and buffers
// finished results so downstream back-pressure stalls the core losslessly.
//   nvdla_core_clk   : core clock
//   nvdla_core_rstn  : asynchronous active-low reset
//   io (slave)       : chn_in_vld/rdy, core_wen, core_res_data,
//                      chn_out_vld/rdy/data, core_idle
// ----------------------------------------------------------------------------
module nv_nvdla_sdp_core_c_core_io_ctrl
   import nv_nvdla_sdp_core_c_core_io_ctrl_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned LAT   = DEF_LAT,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                               nvdla_core_clk,
   input  logic                               nvdla_core_rstn,
   nv_nvdla_sdp_core_c_core_io_ctrl_if.slave  io
);

   localparam int unsigned CNT_W = cnt_width(DEPTH);
   localparam int unsigned PTR_W = ptr_width(DEPTH);

   logic [LAT-1:0]   pipe_vld;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic [DW-1:0]    fifo_head;
   logic             out_pop;
   logic             adv;
   logic             accept;
   logic             wen;
   logic             push;

   // The pipeline freezes only when a finished result has nowhere to go:
   // last stage valid, FIFO full, and the head not leaving this cycle.
   always_comb begin
      out_pop = ~fifo_empty & io.chn_out_rdy;
      adv     = ~(pipe_vld[LAT-1] & fifo_full & ~out_pop);
      accept  = io.chn_in_vld & adv;
      // Advance for new input or to drain bubbles; stay quiet when idle.
      wen     = adv & (io.chn_in_vld | (|pipe_vld));
      push    = wen & pipe_vld[LAT-1];
   end

   generate
      if (LAT == 1) begin : g_pipe_1
         always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) pipe_vld <= '0;
            else if (wen)         pipe_vld <= accept;
         end
      end else begin : g_pipe_n
         always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) pipe_vld <= '0;
            else if (wen)         pipe_vld <= {pipe_vld[LAT-2:0], accept};
         end
      end
   endgenerate

   nv_nvdla_sdp_core_c_res_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk       (nvdla_core_clk),
      .rst_n     (nvdla_core_rstn),
      .push      (push),
      .push_data (io.core_res_data),
      .pop       (out_pop),
      .pop_data  (fifo_head),
      .cnt       (fifo_cnt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign io.chn_in_rdy   = adv;
   assign io.core_wen     = wen;
   assign io.chn_out_vld  = ~fifo_empty;
   assign io.chn_out_data = fifo_head;
   assign io.core_idle    = ~(|pipe_vld) & (fifo_cnt == '0);

endmodule
